// File: rtl/prores_hdr_pkg.sv
// ProRes picture-header sequencer: shared field widths, constants and FSM state type.
package prores_hdr_pkg;

    localparam int unsigned HEADER_SIZE    = 8;
    localparam int unsigned W_HEADER_SIZE  = 5;
    localparam int unsigned W_RSVD0        = 3;
    localparam int unsigned W_PIC_SIZE     = 32;
    localparam int unsigned W_SLICE_NUM    = 16;
    localparam int unsigned W_RSVD1        = 2;
    localparam int unsigned W_LOG2_SLICE   = 2;
    localparam int unsigned W_RSVD2        = 4;
    localparam int unsigned FIELDS_PER_PIC = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_ALIGN = 2'd2,
        ST_DONE  = 2'd3
    } hdr_state_e;

endpackage

// File: rtl/pic_hdr_field_rom.sv
// Combinational field table: (field index, picture index, latched header values)
// -> right-justified field value and its length in bits.
module pic_hdr_field_rom
    import prores_hdr_pkg::*;
#(
    parameter int VAL_W = 64
) (
    input  logic [2:0]       fld_idx_i,
    input  logic             pic_idx_i,
    input  logic [31:0]      pic_size_0_i,
    input  logic [31:0]      pic_size_1_i,
    input  logic [15:0]      slice_num_i,
    input  logic [1:0]       log2_slice_mb_i,
    output logic [VAL_W-1:0] val_o,
    output logic [VAL_W-1:0] size_of_bit_o
);

    logic [31:0] pic_size_s;

    // Select the field value and width for the requested field of the requested picture.
    always_comb begin
        pic_size_s    = pic_idx_i ? pic_size_1_i : pic_size_0_i;
        val_o         = '0;
        size_of_bit_o = '0;
        case (fld_idx_i)
            3'd0: begin
                val_o         = VAL_W'(HEADER_SIZE);
                size_of_bit_o = VAL_W'(W_HEADER_SIZE);
            end
            3'd1: begin
                val_o         = '0;
                size_of_bit_o = VAL_W'(W_RSVD0);
            end
            3'd2: begin
                val_o         = VAL_W'(pic_size_s);
                size_of_bit_o = VAL_W'(W_PIC_SIZE);
            end
            3'd3: begin
                val_o         = VAL_W'(slice_num_i);
                size_of_bit_o = VAL_W'(W_SLICE_NUM);
            end
            3'd4: begin
                val_o         = '0;
                size_of_bit_o = VAL_W'(W_RSVD1);
            end
            3'd5: begin
                val_o         = VAL_W'(log2_slice_mb_i);
                size_of_bit_o = VAL_W'(W_LOG2_SLICE);
            end
            3'd6: begin
                val_o         = '0;
                size_of_bit_o = VAL_W'(W_RSVD2);
            end
            default: begin
                val_o         = '0;
                size_of_bit_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/picture_header_seq.sv
// ProRes picture-header sequencer: on start, emits the 7 header fields of one
// (progressive) or two (interlaced) pictures to a bit-packer under a
// valid/ready handshake. Optional build macro PICTURE_HEADER_SEQ_FLUSH_EN adds
// a byte-align/flush beat after each picture.
module picture_header_seq
    import prores_hdr_pkg::*;
#(
    parameter int VAL_W    = 64,
    parameter int MAX_PICS = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             interlaced,
    input  logic [31:0]      picture_size_0,
    input  logic [31:0]      picture_size_1,
    input  logic [15:0]      slice_num,
    input  logic [1:0]       log2_slice_mb,
    input  logic             out_ready,
    output logic             output_enable,
    output logic [VAL_W-1:0] val,
    output logic [VAL_W-1:0] size_of_bit,
    output logic             flush_bit,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] LAST_FLD = 3'(FIELDS_PER_PIC - 1);

    hdr_state_e       state_q, state_d;
    logic [2:0]       fld_q, fld_d;
    logic             pic_q, pic_d;
    logic             interlaced_q, interlaced_d;
    logic [31:0]      size0_q, size0_d;
    logic [31:0]      size1_q, size1_d;
    logic [15:0]      slice_q, slice_d;
    logic [1:0]       log2_q, log2_d;

    logic             oe_q, oe_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic [VAL_W-1:0] sob_q, sob_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [VAL_W-1:0] rom_val_s;
    logic [VAL_W-1:0] rom_sob_s;
    logic             more_pics_s;

    // The ROM looks at next-state indices so the registered outputs line up with the state.
    pic_hdr_field_rom #(.VAL_W(VAL_W)) u_rom (
        .fld_idx_i       (fld_d),
        .pic_idx_i       (pic_d),
        .pic_size_0_i    (size0_d),
        .pic_size_1_i    (size1_d),
        .slice_num_i     (slice_d),
        .log2_slice_mb_i (log2_d),
        .val_o           (rom_val_s),
        .size_of_bit_o   (rom_sob_s)
    );

    // Next-state, index and latch logic; outputs are derived from the next state.
    always_comb begin
        state_d      = state_q;
        fld_d        = fld_q;
        pic_d        = pic_q;
        interlaced_d = interlaced_q;
        size0_d      = size0_q;
        size1_d      = size1_q;
        slice_d      = slice_q;
        log2_d       = log2_q;
        more_pics_s  = (pic_q == 1'b0) && interlaced_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    interlaced_d = (MAX_PICS > 1) ? interlaced : 1'b0;
                    size0_d      = picture_size_0;
                    size1_d      = picture_size_1;
                    slice_d      = slice_num;
                    log2_d       = log2_slice_mb;
                    state_d      = ST_EMIT;
                    fld_d        = 3'd0;
                    pic_d        = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (fld_q == LAST_FLD) begin
`ifdef PICTURE_HEADER_SEQ_FLUSH_EN
                        state_d = ST_ALIGN;
`else
                        fld_d = 3'd0;
                        if (more_pics_s) begin
                            pic_d = 1'b1;
                        end else begin
                            pic_d   = 1'b0;
                            state_d = ST_DONE;
                        end
`endif
                    end else begin
                        fld_d = fld_q + 3'd1;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_ALIGN: begin
                if (out_ready) begin
                    fld_d = 3'd0;
                    if (more_pics_s) begin
                        pic_d   = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        pic_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                fld_d   = 3'd0;
                pic_d   = 1'b0;
            end
        endcase

        oe_d   = (state_d == ST_EMIT) || (state_d == ST_ALIGN);
        val_d  = (state_d == ST_EMIT) ? rom_val_s : '0;
        sob_d  = (state_d == ST_EMIT) ? rom_sob_s : '0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, indices, latched header values and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            fld_q        <= 3'd0;
            pic_q        <= 1'b0;
            interlaced_q <= 1'b0;
            size0_q      <= 32'd0;
            size1_q      <= 32'd0;
            slice_q      <= 16'd0;
            log2_q       <= 2'd0;
            oe_q         <= 1'b0;
            val_q        <= '0;
            sob_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fld_q        <= fld_d;
            pic_q        <= pic_d;
            interlaced_q <= interlaced_d;
            size0_q      <= size0_d;
            size1_q      <= size1_d;
            slice_q      <= slice_d;
            log2_q       <= log2_d;
            oe_q         <= oe_d;
            val_q        <= val_d;
            sob_q        <= sob_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef PICTURE_HEADER_SEQ_FLUSH_EN
    logic flush_q;

    // Flush request is asserted for the whole (possibly stalled) align beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= (state_d == ST_ALIGN);
        end
    end

    assign flush_bit = flush_q;
`else
    assign flush_bit = 1'b0;
`endif

    assign output_enable = oe_q;
    assign val           = val_q;
    assign size_of_bit   = sob_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_picture_header_seq.sv
// Self-checking bench for picture_header_seq: table of header runs with
// scoreboard of expected beats, plus hand-written reset-mid-sequence case.
module tb_picture_header_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        interlaced;
    logic [31:0] picture_size_0;
    logic [31:0] picture_size_1;
    logic [15:0] slice_num;
    logic [1:0]  log2_slice_mb;
    logic        out_ready;
    logic        output_enable;
    logic [63:0] val;
    logic [63:0] size_of_bit;
    logic        flush_bit;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    picture_header_seq #(.VAL_W(64), .MAX_PICS(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .interlaced     (interlaced),
        .picture_size_0 (picture_size_0),
        .picture_size_1 (picture_size_1),
        .slice_num      (slice_num),
        .log2_slice_mb  (log2_slice_mb),
        .out_ready      (out_ready),
        .output_enable  (output_enable),
        .val            (val),
        .size_of_bit    (size_of_bit),
        .flush_bit      (flush_bit),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic        il;
        logic [31:0] ps0;
        logic [31:0] ps1;
        logic [15:0] sn;
        logic [1:0]  lg;
        int          stall_beat;
        int          stall_len;
        int          restart_beat;
    } vec_t;

    typedef struct {
        logic [63:0] v;
        logic [63:0] s;
        logic        f;
    } beat_t;

    beat_t exp_q[$];
    vec_t  vecs[6];
    int    n_total = 0;
    int    n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_beat(input logic [63:0] v, input logic [63:0] s, input logic f);
        beat_t b;
        b.v = v; b.s = s; b.f = f;
        exp_q.push_back(b);
    endtask

    // Expected beats of one picture header, written from the field table.
    task automatic push_pic(input logic [31:0] ps, input logic [15:0] sn, input logic [1:0] lg);
        push_beat(64'd8, 64'd5, 1'b0);
        push_beat(64'd0, 64'd3, 1'b0);
        push_beat({32'd0, ps}, 64'd32, 1'b0);
        push_beat({48'd0, sn}, 64'd16, 1'b0);
        push_beat(64'd0, 64'd2, 1'b0);
        push_beat({62'd0, lg}, 64'd2, 1'b0);
        push_beat(64'd0, 64'd4, 1'b0);
`ifdef PICTURE_HEADER_SEQ_FLUSH_EN
        push_beat(64'd0, 64'd0, 1'b1);
`endif
    endtask

    task automatic drive_inputs(input vec_t v);
        interlaced     = v.il;
        picture_size_0 = v.ps0;
        picture_size_1 = v.ps1;
        slice_num      = v.sn;
        log2_slice_mb  = v.lg;
    endtask

    task automatic run_vec(input vec_t v);
        int  beats;
        int  stall_left;
        int  b;
        int  k;
        bit  got_done;
        exp_q.delete();
        push_pic(v.ps0, v.sn, v.lg);
        if (v.il) push_pic(v.ps1, v.sn, v.lg);
        beats      = exp_q.size();
        stall_left = (v.stall_beat >= 0) ? v.stall_len : 0;
        b          = 0;
        got_done   = 1'b0;
        // cycle N: request
        @(negedge clock);
        drive_inputs(v);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        k     = 1;
        start = 1'b0;
        // scramble inputs: the latched copy must be used
        interlaced     = ~v.il;
        picture_size_0 = $urandom;
        picture_size_1 = $urandom;
        slice_num      = 16'($urandom);
        log2_slice_mb  = 2'($urandom);
        chk("first_beat_latency", {63'd0, output_enable}, 64'd1);
        while (!got_done && k < 300) begin
            if (done) begin
                got_done = 1'b1;
                chk("done_cycle", 64'(k), 64'(beats + ((v.stall_beat >= 0) ? v.stall_len : 0) + 1));
                chk("all_beats_seen", 64'(exp_q.size()), 64'd0);
                chk("oe_low_in_done", {63'd0, output_enable}, 64'd0);
                chk("busy_in_done", {63'd0, busy}, 64'd1);
            end else begin
                if (output_enable) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'd1, 64'd0);
                    end else begin
                        chk("beat_val", val, exp_q[0].v);
                        chk("beat_size", size_of_bit, exp_q[0].s);
                        chk("beat_flush", {63'd0, flush_bit}, {63'd0, exp_q[0].f});
                    end
                end else begin
                    chk("unexpected_bubble", 64'd1, 64'd0);
                end
                start = (output_enable && b == v.restart_beat) ? 1'b1 : 1'b0;
                if (start) begin
                    picture_size_0 = 32'hDEAD_BEEF;
                    interlaced     = 1'b1;
                end
                if (b == v.stall_beat && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    if (output_enable && exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        b++;
                    end
                end
                @(negedge clock);
                k++;
            end
        end
        if (!got_done) chk("done_timeout", 64'd1, 64'd0);
        start = 1'b0;
        @(negedge clock);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        chk("idle_val_zero", val | size_of_bit, 64'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        interlaced     = 1'b0;
        picture_size_0 = 32'd0;
        picture_size_1 = 32'd0;
        slice_num      = 16'd0;
        log2_slice_mb  = 2'd0;
        out_ready      = 1'b1;

        //           il    ps0            ps1           sn         lg    stall  len  restart
        vecs[0] = '{1'b0, 32'h0000_042E, 32'h0,        16'd1,     2'd3, -1,    0,   -1};
        vecs[1] = '{1'b1, 32'h0000_0100, 32'h0000_0200, 16'h1234, 2'd2, -1,    0,   -1};
        vecs[2] = '{1'b0, 32'h0000_042E, 32'h0,        16'd1,     2'd3,  2,    3,   -1};
        vecs[3] = '{1'b0, 32'h0000_042E, 32'h0,        16'd1,     2'd3, -1,    0,    3};
        vecs[4] = '{1'b1, 32'hCAFE_0001, 32'h0BAD_F00D, 16'h00A5, 2'd1,  6,    2,   -1};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        16'hFFFF,  2'd3,  0,    1,   -1};

        repeat (3) @(negedge clock);
        chk("reset_oe", {63'd0, output_enable}, 64'd0);
        chk("reset_val", val, 64'd0);
        chk("reset_size", size_of_bit, 64'd0);
        chk("reset_busy_done_flush", {61'd0, busy, done, flush_bit}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // reset asserted while the fifth beat is presented
        begin
            int b = 0;
            int k = 0;
            exp_q.delete();
            @(negedge clock);
            drive_inputs(vecs[0]);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            while (b < 4 && k < 50) begin
                if (output_enable) b++;
                @(negedge clock);
                k++;
            end
            chk("pre_reset_beat5", val, 64'd0);
            chk("pre_reset_size5", size_of_bit, 64'd2);
            reset_n = 1'b0;
            @(negedge clock);
            chk("midreset_oe", {63'd0, output_enable}, 64'd0);
            chk("midreset_val", val, 64'd0);
            chk("midreset_size", size_of_bit, 64'd0);
            chk("midreset_busy_done_flush", {61'd0, busy, done, flush_bit}, 64'd0);
            @(negedge clock);
            reset_n = 1'b1;
            repeat (2) @(negedge clock);
            chk("no_resume_after_reset", {63'd0, output_enable}, 64'd0);
        end
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
